// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (start/data/parity/stop, LSB first).
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry input FIFO in front of the shifter.
module uart_tx_cfg #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              tx_clk,
  input  logic              reset_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_done,
  output logic              tx_busy,
  output logic              tx
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);
  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] shift, load_data;
  logic par, tick, last_stop, load, have;
  assign tick = timer == '0;
  assign last_stop = state == STOP && tick && idx == IW'(STOP_BITS - 1);
  assign tx_done = last_stop;
`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic push, empty, full;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign tx_ready = !full;
  assign push = tx_valid && !full;
  assign have = !empty;
  assign load_data = mem[rp[AW-1:0]];
  // the pop happens in the final stop cycle too, so queued frames run gap-free
  assign load = have && (state == IDLE || last_stop);
  assign tx_busy = state != IDLE || !empty;
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (load) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge tx_clk)
    if (push) mem[wp[AW-1:0]] <= tx_data;
`else
  assign tx_ready = state == IDLE;
  assign have = tx_valid;
  assign load_data = tx_data;
  assign load = have && state == IDLE;
  assign tx_busy = state != IDLE;
`endif
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (load) state_nx = START;
      START:   if (tick) state_nx = DATA;
      DATA:    if (tick && idx == IW'(DATA_W - 1)) state_nx = PAR_EN ? PAR : STOP;
      PAR:     if (tick) state_nx = STOP;
      STOP:    if (last_stop) state_nx = load ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_nx;
      tx    <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PAR ? par : 1'b1;
      timer <= (state == IDLE || tick) ? RELOAD : timer - 1'b1;
      if ((state == DATA || state == STOP) && tick)
        idx <= ((state == DATA && idx == IW'(DATA_W - 1)) || last_stop) ? '0 : idx + 1'b1;
      if (load) begin
        shift <= load_data;
        par   <= ^load_data ^ (PARITY == 1);
      end else if (state == DATA && tick) begin
        shift <= shift >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: three differently configured transmitters checked against a frame-level model.
module tb_uart_tx_cfg;
  localparam int DW  [3] = '{8, 8, 7};
  localparam int CPB [3] = '{4, 4, 2};
  localparam int PAR [3] = '{2, 1, 0};
  localparam int SB  [3] = '{1, 1, 2};
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] valid = '0;
  logic [7:0] data [3];
  logic [2:0] ready, done, busy, line;
  int checks = 0;
  int failures = 0;
  logic cap_tx [512];
  logic cap_done [512];
  logic cap_busy [512];
  logic cap_ready [512];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .tx_clk(clk), .reset_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(ready[0]), .tx_done(done[0]), .tx_busy(busy[0]), .tx(line[0]));
  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .tx_clk(clk), .reset_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(ready[1]), .tx_done(done[1]), .tx_busy(busy[1]), .tx(line[1]));
  uart_tx_cfg #(.DATA_W(7), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .tx_clk(clk), .reset_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2][6:0]),
    .tx_ready(ready[2]), .tx_done(done[2]), .tx_busy(busy[2]), .tx(line[2]));

  function automatic int flen(input int u);
    return (1 + DW[u] + ((PAR[u] == 1 || PAR[u] == 2) ? 1 : 0) + SB[u]) * CPB[u];
  endfunction

  // line sample index where frame k starts (samples taken at the negedge after edge T+j)
  function automatic int start_of(input int u, input int k);
    return LAT + k * (flen(u) + (LAT == 1 ? 1 : 0));
  endfunction

  function automatic logic frame_bit(input int u, input logic [7:0] w, input int p);
    int ones = 0;
    for (int i = 0; i < DW[u]; i++) ones += int'(w[i]);
    if (p == 0) return 1'b0;
    if (p <= DW[u]) return w[p-1];
    if (p == DW[u] + 1 && (PAR[u] == 1 || PAR[u] == 2)) return (PAR[u] == 1) ? ~ones[0] : ones[0];
    return 1'b1;
  endfunction

  function automatic int first_done(input int n);
    for (int j = 0; j < n; j++) if (cap_done[j]) return j;
    return -1;
  endfunction

  task automatic run_stream(input int u, input logic [7:0] w [$], input int n_exp, input bit stop_full, input string name);
    int f = flen(u);
    int n = start_of(u, n_exp - 1) + f + 4;
    int i = 0;
    int bad_tx = 0, bad_done = 0, bad_busy = 0, bad_rdy = 0, first_bad = -1;
    bit rdy, open = 1'b1;
    @(negedge clk);
    checks++;
    if (ready[u] !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_ready: got %b want 1", name, ready[u]);
    end
    valid[u] = 1'b1;
    data[u] = w[0];
    rdy = ready[u];
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      if (rdy && valid[u]) i++;
      @(negedge clk);
      cap_tx[j] = line[u];
      cap_done[j] = done[u];
      cap_busy[j] = busy[u];
      cap_ready[j] = ready[u];
      rdy = ready[u];
      if (stop_full && !rdy) open = 1'b0;
      valid[u] = open && i < w.size();
      data[u] = (i < w.size()) ? w[i] : 8'h00;
    end
    valid[u] = 1'b0;
    for (int j = 0; j < n; j++) begin
      logic e_tx = 1'b1, e_done = 1'b0, e_busy = 1'b0;
      for (int k = 0; k < n_exp; k++) begin
        int s = start_of(u, k);
        if (j >= s && j < s + f) e_tx = frame_bit(u, w[k], (j - s) / CPB[u]);
        if (j == s + f - 2) e_done = 1'b1;
        if (j >= s - LAT && j <= s + f - 2) e_busy = 1'b1;
      end
      if (cap_tx[j] !== e_tx) begin bad_tx++; if (first_bad < 0) first_bad = j; end
      if (cap_done[j] !== e_done) begin bad_done++; if (first_bad < 0) first_bad = j; end
      if (cap_busy[j] !== e_busy) begin bad_busy++; if (first_bad < 0) first_bad = j; end
`ifndef UART_TX_FIFO_EN
      if (cap_ready[j] !== !e_busy) begin bad_rdy++; if (first_bad < 0) first_bad = j; end
`endif
    end
    checks += 5;
    if (i != n_exp) begin
      failures++;
      $display("FAIL %s accepted: got %0d want %0d", name, i, n_exp);
    end
    if (bad_tx != 0) begin failures++; $display("FAIL %s tx: %0d bad samples want 0 (first at %0d)", name, bad_tx, first_bad); end
    if (bad_done != 0) begin failures++; $display("FAIL %s tx_done: %0d bad samples want 0 (first at %0d)", name, bad_done, first_bad); end
    if (bad_busy != 0) begin failures++; $display("FAIL %s tx_busy: %0d bad samples want 0 (first at %0d)", name, bad_busy, first_bad); end
    if (bad_rdy != 0) begin failures++; $display("FAIL %s tx_ready: %0d bad samples want 0 (first at %0d)", name, bad_rdy, first_bad); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      for (int u = 0; u < 3; u++) begin
        checks++;
        if ({line[u], ready[u], done[u], busy[u]} !== 4'b1100) begin
          failures++;
          $display("FAIL reset_state u%0d pass%0d: got tx,ready,done,busy=%b want 1100", u, pass,
                   {line[u], ready[u], done[u], busy[u]});
        end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_frame_a5;
    logic [7:0] q [$];
    logic [10:0] e = 11'b10101001010;
    int bad = 0;
    q = {8'hA5};
    run_stream(0, q, 1, 1'b0, "frame_a5");
    for (int b = 0; b < 11; b++)
      for (int c = 0; c < 4; c++) if (cap_tx[LAT + 4*b + c] !== e[b]) bad++;
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL a5_bits: %0d bad samples want 0", bad); end
    if (first_done(100) != LAT + 44 - 2) begin
      failures++;
      $display("FAIL a5_done_pos: got %0d want %0d", first_done(100), LAT + 42);
    end
  endtask

  task automatic test_parity_odd;
    logic [7:0] q [$];
    q = {8'h01};
    run_stream(1, q, 1, 1'b0, "odd_01");
    checks++;
    if (cap_tx[LAT + 9*4 + 1] !== 1'b0) begin failures++; $display("FAIL odd_par_01: got %b want 0", cap_tx[LAT + 37]); end
    q = {8'h03};
    run_stream(1, q, 1, 1'b0, "odd_03");
    checks++;
    if (cap_tx[LAT + 9*4 + 1] !== 1'b1) begin failures++; $display("FAIL odd_par_03: got %b want 1", cap_tx[LAT + 37]); end
  endtask

  task automatic test_frame_7f;
    logic [7:0] q [$];
    q = {8'h7F};
    run_stream(2, q, 1, 1'b0, "frame_7f");
    checks += 2;
    if (first_done(100) != LAT + 20 - 2) begin
      failures++;
      $display("FAIL 7f_len: done at %0d want %0d", first_done(100), LAT + 18);
    end
    if ({cap_tx[LAT+16], cap_tx[LAT+17], cap_tx[LAT+18], cap_tx[LAT+19]} !== 4'b1111) begin
      failures++;
      $display("FAIL 7f_stop: got %b%b%b%b want 1111", cap_tx[LAT+16], cap_tx[LAT+17], cap_tx[LAT+18], cap_tx[LAT+19]);
    end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    for (int u = 0; u < 3; u++)
      for (int r = 0; r < 2; r++) begin
        q = {8'($urandom_range(0, 255))};
        run_stream(u, q, 1, 1'b0, $sformatf("rand_u%0d_%0d", u, r));
      end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q [$];
    q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    run_stream(0, q, 2, 1'b0, "b2b_u0");
    q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    run_stream(2, q, 2, 1'b0, "b2b_u2");
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo_fill;
    logic [7:0] q [$];
    int last = -1;
    q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    run_stream(0, q, 5, 1'b1, "fifo_fill");
    for (int j = 0; j < 400; j++) if (cap_done[j]) last = j;
    checks++;
    if (last < 0 || cap_busy[last] !== 1'b1 || cap_busy[last+1] !== 1'b0) begin
      failures++;
      $display("FAIL fifo_busy_fall: last done at %0d, busy there/after got %b%b want 10", last,
               (last < 0) ? 1'bx : cap_busy[last], (last < 0) ? 1'bx : cap_busy[last+1]);
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [7:0] q [$];
    int dones = 0, lows = 0;
    @(negedge clk);
    valid[0] = 1'b1;
    data[0] = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    checks++;
    if (line[0] !== frame_bit(0, 8'hA5, (12 - LAT) / CPB[0])) begin
      failures++;
      $display("FAIL mid_frame_tx: got %b want %b", line[0], frame_bit(0, 8'hA5, (12 - LAT) / CPB[0]));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({line[0], ready[0], done[0], busy[0]} !== 4'b1100) begin
      failures++;
      $display("FAIL async_reset: got tx,ready,done,busy=%b want 1100", {line[0], ready[0], done[0], busy[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < flen(0) + 4; j++) begin
      @(negedge clk);
      if (done[0]) dones++;
      if (!line[0]) lows++;
    end
    checks++;
    if (dones != 0 || lows != 0) begin
      failures++;
      $display("FAIL abandoned_frame: got %0d done pulses, %0d low samples want 0,0", dones, lows);
    end
    q = {8'($urandom_range(0, 255))};
    run_stream(0, q, 1, 1'b0, "after_reset");
  endtask

  initial begin
    data[0] = '0;
    data[1] = '0;
    data[2] = '0;
    test_reset;
    test_frame_a5;
    test_parity_odd;
    test_frame_7f;
    test_random;
    test_back_to_back;
`ifdef UART_TX_FIFO_EN
    test_fifo_fill;
`endif
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter and successor to `tx_core`. It accepts parallel words over a valid/ready handshake and serialises them LSB-first as start / data / optional parity / stop frames on `tx`. Word width, baud divisor, parity mode and stop-bit count are configurable. It sits in the UART Avalon slave between the register/CSR logic and the pad, and can optionally buffer words in an input FIFO.

## Interface
- `DATA_W`, default 8: data bits per frame, legal range 5..9.
- `CLKS_PER_BIT`, default 16: `tx_clk` cycles per bit period, minimum 2.
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even. Value 3 is treated as 0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, default 4: input FIFO entries, a power of 2 and at least 2. Used only with `UART_TX_FIFO_EN`.
- `tx_clk`  in  1  the block's single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `tx_valid`  in  1  `tx_data` holds a word to send.
- `tx_data`  in  DATA_W  word to send; bit 0 is transmitted first.
- `tx_ready`  out  1  the block can accept a word this cycle.
- `tx_done`  out  1  one-cycle pulse when the last stop bit of a frame completes.
- `tx_busy`  out  1  a frame is on the line, or words are waiting to be sent.
- `tx`  out  1  serial line, idle high, registered.

## Operation
- Handshake: a word transfers on a rising edge where `tx_valid` and `tx_ready` are both 1. Holding `tx_valid` high sends back-to-back words. `tx_data` is sampled only at the transfer edge.
- FSM states:
  - IDLE: `tx` = 1.
  - START: `tx` = 0.
  - DATA: bits 0..DATA_W-1, taken from a shift register.
  - PAR: present only if `PARITY` is not 0.
  - STOP: `tx` = 1 for `STOP_BITS` bit periods.
- Transitions:
  - IDLE→START when a word is available (transfer, or FIFO not empty).
  - START→DATA after one bit period.
  - DATA→PAR (or STOP if no parity) after DATA_W bit periods.
  - PAR→STOP after one bit period.
  - STOP→IDLE, or directly START when `UART_TX_FIFO_EN` is defined and the FIFO is not empty.
- Bit timer: a down-counter of `$clog2(CLKS_PER_BIT)` bits. It reloads `CLKS_PER_BIT-1` on every bit boundary. A bit index counter counts data bits and stop bits.
- Parity: the XOR-reduction of the latched word. Odd mode sends its inverse; even mode sends it unchanged. It is computed at latch time.
- `tx_done` pulses in the final cycle of the last stop bit.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous). The FSM returns to IDLE, the FIFO empties, and the partial frame is abandoned with no `tx_done`.

## Timing
- Reset values: `tx` = 1, `tx_ready` = 1, `tx_done` = 0, `tx_busy` = 0.
- Frame length: F = (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Without FIFO, transfer at edge T:
  - `tx` falls at edge T+1.
  - `tx_done` is high in cycle T+F.
  - `tx_ready` is 0 from T+1 until the FSM re-enters IDLE at T+F+1.
  - So continuous streaming inserts one extra idle-high cycle between frames.
- With FIFO:
  - `tx` falls 2 edges after the push (push, then pop into the shifter).
  - Queued frames follow with zero gap; the next START begins the cycle after `tx_done`.
- `tx_busy` = (state ≠ IDLE) or FIFO not empty.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - A `FIFO_DEPTH`-entry FIFO sits in front of the shifter, with `tx_ready` = FIFO not full.
  - The shifter pops the FIFO when in IDLE, or in the last STOP cycle.
  - A push into a full FIFO never occurs, because `tx_ready` is 0.
  - A simultaneous push and pop when full is not allowed: ready is computed before the pop.
  - When the FIFO is empty and the FSM is idle, a push is not bypassed; it is still popped on the next cycle.
- Not defined:
  - No storage beyond the shift register.
  - `tx_ready` = (state == IDLE).
  - The word loads directly at the transfer edge.

## Test plan
- DATA_W=8, CLKS_PER_BIT=4, PARITY=2, STOP_BITS=1; send 0xA5 → `tx` sends 0,1,0,1,0,0,1,0,1, parity 0, stop 1, each bit held 4 cycles; `tx_done` pulses exactly 44 cycles after the transfer edge.
- PARITY=1; send 0x01 → parity bit is 0. Send 0x03 → parity bit is 1.
- DATA_W=7, STOP_BITS=2, PARITY=0, CLKS_PER_BIT=2; send 0x7F → start 0, seven 1s, stop high for 4 cycles; frame length 20 cycles.
- Assert `reset_n` low in the middle of the DATA state → `tx` = 1 in the same cycle, no `tx_done`, `tx_ready` = 1; the next word after release transmits correctly.
- `UART_TX_FIFO_EN`, FIFO_DEPTH=4: hold `tx_valid` high with words 0x11..0x16 → exactly 5 words accepted (one in the shifter, 4 queued) before `tx_ready` drops; all 5 are sent with no idle cycles between frames; `tx_busy` falls after the 5th `tx_done`.
- Without FIFO: hold `tx_valid` high for 2 words → exactly one idle-high cycle between the first frame's stop bit and the second frame's start bit.
